// File: rtl/otter_regfile_sb.sv
// OTTER integer register file: NRD combinational read ports, one writeback port with
// optional same-cycle bypass, and a per-register pending-write scoreboard.
module otter_regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int PCW    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [XLEN-1:0]      wr_data,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  output logic                 rsv_ready,
  input  logic                 flush,
  output logic [NREG-1:0]      busy_vec
);

  localparam logic [PCW-1:0] PEND_MAX = '1;

  logic [XLEN-1:0] data_q [1:NREG-1];
  logic [PCW-1:0]  pend_q [1:NREG-1];
  logic [PCW-1:0]  pend_d [1:NREG-1];
  logic [NREG-1:1] inc, dec;

  // Reserve handshake: a reservation takes effect on an edge only when rsv_en and
  // rsv_ready are both high; with rsv_ready low the request is dropped, never queued.
  always_comb begin
    inc       = '0;
    dec       = '0;
    busy_vec  = '0;
    rsv_ready = 1'b1;
    for (int r = 1; r < NREG; r++) begin
      busy_vec[r] = (pend_q[r] != '0);
      if (rsv_addr == AW'(r)) rsv_ready = (pend_q[r] != PEND_MAX);
      inc[r] = rsv_en && (rsv_addr == AW'(r)) && (pend_q[r] != PEND_MAX);
      dec[r] = wr_en && (wr_addr == AW'(r)) && (pend_q[r] != '0);
      pend_d[r] = pend_q[r];
      if (flush)               pend_d[r] = '0;
      else if (inc[r] && !dec[r]) pend_d[r] = pend_q[r] + PCW'(1);
      else if (dec[r] && !inc[r]) pend_d[r] = pend_q[r] - PCW'(1);
    end
  end

  // r0 and out-of-range addresses match no entry and therefore read 0 / not busy.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      for (int r = 1; r < NREG; r++) begin
        if (rd_addr[i*AW +: AW] == AW'(r)) begin
          rd_data[i*XLEN +: XLEN] = data_q[r];
          rd_busy[i]              = (pend_q[r] != '0);
          if ((BYPASS != 0) && wr_en && (wr_addr == AW'(r))) begin
            rd_data[i*XLEN +: XLEN] = wr_data;
            if (dec[r] && !inc[r] && (pend_q[r] == PCW'(1))) rd_busy[i] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 1; r < NREG; r++) begin
        data_q[r] <= '0;
        pend_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (wr_en && (wr_addr == AW'(r))) data_q[r] <= wr_data;
        pend_q[r] <= pend_d[r];
      end
    end
  end

endmodule
